ram_dp_param: RTL
=================

Name: ram_dp_param

Overview:
- Parametrised successor to the team's 8-bit, 64-entry dual-read RAM used as the matrix operand store in the matrix-multiply datapath.
- One write port and two independent read ports, generalised in width and depth.
- Adds reset, a post-reset clear sequencer, per-port read enables with valid flags, write-first forwarding and out-of-range protection.
- Sits between the operand loader (writer) and the MAC array (two readers: row and column operand).

Parameters:
DATA_W, 8, data width in bits (signed two's complement)
ADDR_W, 6, address width in bits
DEPTH, 64, number of entries; legal range 2..2**ADDR_W
CLEAR_ON_RESET, 1, 1 = zero all entries after reset; 0 = no clear, contents untouched by reset

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  signed write data
re1  input  1  read enable, port 1
raddr1  input  ADDR_W  read address, port 1
re2  input  1  read enable, port 2
raddr2  input  ADDR_W  read address, port 2
rdata1  output  DATA_W  signed read data, port 1
rdata2  output  DATA_W  signed read data, port 2
rvalid1  output  1  rdata1 valid strobe
rvalid2  output  1  rdata2 valid strobe
busy  output  1  clear sequence in progress; all requests ignored

Behaviour:
- Reset: single clock, synchronous, active-low (rst_n low at a rising clk edge).
  - rdata1/rdata2 = 0, rvalid1/rvalid2 = 0.
  - busy = 1 if CLEAR_ON_RESET else 0.
  - Clear counter = 0.
  - Memory contents are not otherwise modified by reset.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET, else READY.
  - In CLEAR, each cycle with rst_n high writes 0 to entry cnt, then cnt increments.
  - After entry DEPTH-1 is written: state = READY, busy = 0 on the next edge. Clear takes exactly DEPTH cycles after rst_n rises.
  - Reset asserted mid-clear restarts the clear at entry 0.
- While busy:
  - we, re1 and re2 are ignored.
  - rvalid1/rvalid2 = 0 and rdata holds 0.
- Write: we=1 in READY with waddr < DEPTH updates mem[waddr] at that edge. waddr >= DEPTH is dropped silently.
- Read latency is 1 cycle.
  - re1=1 at edge N: rdata1 = mem[raddr1] and rvalid1 = 1 after edge N.
  - re1=0: rvalid1 = 0 and rdata1 holds its last value.
  - Port 2 behaves identically and independently.
- Both ports may read the same address in the same cycle; each returns the same data.
- Read-during-write, same address, same cycle: the read returns wdata (write-first forwarding), on either or both ports.
- Read with raddr >= DEPTH returns 0 with rvalid = 1. No wrap-around: addresses are never taken modulo DEPTH.
- Simultaneous write and two reads to three different addresses are all serviced in the same cycle.
- Data is stored and returned unmodified: no sign extension or truncation inside the block.

Optional Feature:
- Macro: RAM_DP_OUTREG_EN.
- Defined:
  - Adds a second output register stage on both ports; read latency becomes 2 cycles.
  - rvalid is pipelined alongside the data.
  - Write-first forwarding is still decided in the first stage.
  - Reset clears both stages to 0/invalid.
  - Back-to-back reads still give one result per cycle.
- Undefined: single stage, latency 1, as described under Behaviour.

Test Plan:
1. Reset and clear, CLEAR_ON_RESET=1, DEPTH=64: hold rst_n low 2 cycles, then release → busy high for exactly 64 cycles. Reads issued during busy give rvalid=0. Afterwards, a read of each of addresses 0..63 returns 0.
2. Write then dual read: write mem[5]=-3 (0xFD) and mem[10]=127; next cycle re1 with raddr1=5 and re2 with raddr2=10 → one cycle later rdata1=-3, rdata2=127, both rvalid=1.
3. Read-during-write: mem[7]=1; same cycle we=1, waddr=7, wdata=-128, re1=re2=1, raddr1=raddr2=7 → both ports return -128. Next-cycle read of 7 also returns -128.
4. Bounds, DEPTH=48, ADDR_W=6: write 55 to address 50; read address 50 → rdata=0, rvalid=1. mem[50 mod 48 = 2] is unchanged.
5. Reset mid-clear: pulse rst_n low at clear count 20 → clear restarts from 0, busy stays high for 64 further cycles.
6. With RAM_DP_OUTREG_EN: read addresses 1, 2, 3 on consecutive cycles (preloaded 11, 22, 33) → data appears 2 cycles after each request as 11, 22, 33, with rvalid high for exactly 3 consecutive cycles.

Source files
------------

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised 1W/2R RAM with post-reset clear, write-first forwarding and bounds checks.
// Optional macro RAM_DP_OUTREG_EN adds a second output register stage (read latency 2).
module ram_dp_param #(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 6,
   parameter int DEPTH          = 64,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic signed [DATA_W-1:0] wdata,
   input  logic                     re1,
   input  logic [ADDR_W-1:0]        raddr1,
   input  logic                     re2,
   input  logic [ADDR_W-1:0]        raddr2,
   output logic signed [DATA_W-1:0] rdata1,
   output logic signed [DATA_W-1:0] rdata2,
   output logic                     rvalid1,
   output logic                     rvalid2,
   output logic                     busy
);
   typedef enum logic {CLEAR, READY} state_t;
   // One extra bit so DEPTH == 2**ADDR_W stays representable in the bound.
   localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
   localparam state_t            INIT = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
   state_t                     state;
   logic [ADDR_W-1:0]          cnt;
   logic signed [DATA_W-1:0]   mem [DEPTH];
   logic                       ok_w;
   logic signed [DATA_W-1:0]   fwd1, fwd2, d1, d2;
   logic                       v1, v2;
   always_comb begin
      ok_w = we && ({1'b0, waddr} < LIM);
      fwd1 = ({1'b0, raddr1} < LIM) ? ((ok_w && waddr == raddr1) ? wdata : mem[raddr1]) : '0;
      fwd2 = ({1'b0, raddr2} < LIM) ? ((ok_w && waddr == raddr2) ? wdata : mem[raddr2]) : '0;
   end
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) mem[cnt] <= '0;
         else if (ok_w) mem[waddr] <= wdata;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         d1    <= '0;
         d2    <= '0;
      end else if (state == CLEAR) begin
         cnt   <= cnt + 1'b1;
         state <= (cnt == LAST) ? READY : CLEAR;
         v1    <= 1'b0;
         v2    <= 1'b0;
         d1    <= '0;
         d2    <= '0;
      end else begin
         v1 <= re1;
         v2 <= re2;
         if (re1) d1 <= fwd1;
         if (re2) d2 <= fwd2;
      end
   end
   assign busy = (state == CLEAR);
`ifdef RAM_DP_OUTREG_EN
   logic signed [DATA_W-1:0] q1, q2;
   logic                     qv1, qv2;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q1  <= '0;
         q2  <= '0;
         qv1 <= 1'b0;
         qv2 <= 1'b0;
      end else begin
         q1  <= d1;
         q2  <= d2;
         qv1 <= v1;
         qv2 <= v2;
      end
   end
   assign rdata1  = q1;
   assign rdata2  = q2;
   assign rvalid1 = qv1;
   assign rvalid2 = qv2;
`else
   assign rdata1  = d1;
   assign rdata2  = d2;
   assign rvalid1 = v1;
   assign rvalid2 = v2;
`endif
endmodule
